// File: rtl/timer_sched_pkg_311.sv
// Shared constants for the two-requester countdown scheduler: FSM encodings,
// the default counter width and the round-robin pick helper.
package timer_sched_pkg_311;

  localparam int WIDTH_DEFAULT = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // last_served = 1 means requester 1 was served most recently, so 0 wins a tie
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_served);
    logic [1:0] pick;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last_served ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/down_counter_ld_311.sv
// Loadable down counter that saturates at zero; load takes priority over enable.
module down_counter_ld_311 #(
  parameter int WIDTH = 8
) (
  input  logic             clk_311,
  input  logic             reset_311,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk_311) begin
    if (reset_311)
      count <= '0;
    else if (load)
      count <= load_value;
    else if (enable && count != '0)
      count <= count - WIDTH'(1);
  end

endmodule

// File: rtl/timer_sched_311.sv
// Round-robin countdown scheduler: two requesters share one down counter.
// Optional macro TIMER_SCHED_PAUSE_EN adds pause_311, which freezes a running countdown.
module timer_sched_311
  import timer_sched_pkg_311::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk_311,
  input  logic             reset_311,
  input  logic [1:0]       req_311,
  input  logic [WIDTH-1:0] len0_311,
  input  logic [WIDTH-1:0] len1_311,
`ifdef TIMER_SCHED_PAUSE_EN
  input  logic             pause_311,
`endif
  output logic [1:0]       grant_311,
  output logic             busy_311,
  output logic [WIDTH-1:0] count_311,
  output logic [1:0]       done_311
);

  logic [1:0]       state;
  logic             last_served;
  logic [1:0]       pick;
  logic             start;
  logic             run_en;
  logic [WIDTH-1:0] load_value;

  assign pick       = rr_pick(req_311, last_served);
  assign start      = (state == ST_IDLE) && (req_311 != 2'b00);
  assign load_value = pick[1] ? len1_311 : len0_311;

`ifdef TIMER_SCHED_PAUSE_EN
  assign run_en = (state == ST_RUN) && !pause_311;
`else
  assign run_en = (state == ST_RUN);
`endif

  assign busy_311 = (state == ST_RUN) || (state == ST_DONE);
  assign done_311 = (state == ST_DONE) ? grant_311 : 2'b00;

  down_counter_ld_311 #(.WIDTH(WIDTH)) u_counter (
    .clk_311    (clk_311),
    .reset_311  (reset_311),
    .load       (start),
    .load_value (load_value),
    .enable     (run_en),
    .count      (count_311)
  );

  // The pointer only moves when a countdown completes, so an aborted job leaves no trace
  always_ff @(posedge clk_311) begin
    if (reset_311) begin
      state       <= ST_IDLE;
      grant_311   <= 2'b00;
      last_served <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_RUN;
            grant_311 <= pick;
          end
        end
        ST_RUN: begin
          if (run_en && count_311 == '0)
            state <= ST_DONE;
        end
        ST_DONE: begin
          state       <= ST_IDLE;
          grant_311   <= 2'b00;
          last_served <= grant_311[1];
        end
        default: begin
          state     <= ST_IDLE;
          grant_311 <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_sched_311.sv
// Self-checking bench for timer_sched_311: directed scenarios plus random traffic
// compared against a job-timeline reference model.
module tb_timer_sched_311;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req;
  logic [W-1:0] len0;
  logic [W-1:0] len1;
  logic         pause;
  logic [1:0]   grant;
  logic         busy;
  logic [W-1:0] count;
  logic [1:0]   done;

  int    test_count = 0;
  int    fail_count = 0;
  string phase = "reset";

  // Reference model: a job is an owner, a length and the number of edges since grant
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_len   = 0;
  int m_el    = 0;
  int m_last  = 1;

  always #5 clk = ~clk;

  timer_sched_311 #(.WIDTH(W)) dut (
    .clk_311   (clk),
    .reset_311 (reset),
    .req_311   (req),
    .len0_311  (len0),
    .len1_311  (len1),
`ifdef TIMER_SCHED_PAUSE_EN
    .pause_311 (pause),
`endif
    .grant_311 (grant),
    .busy_311  (busy),
    .count_311 (count),
    .done_311  (done)
  );

  function automatic logic [1:0] expGrant();
    if (!m_busy) return 2'b00;
    return (m_owner == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic int expCount();
    if (m_busy && m_el <= m_len) return m_len - m_el;
    return 0;
  endfunction

  function automatic logic [1:0] expDone();
    if (m_busy && m_el == m_len + 1) return expGrant();
    return 2'b00;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    test_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic modelStep();
    bit pz;
`ifdef TIMER_SCHED_PAUSE_EN
    pz = pause;
`else
    pz = 1'b0;
`endif
    if (reset) begin
      m_busy = 1'b0;
      m_last = 1;
    end else if (!m_busy) begin
      if (req != 2'b00) begin
        if (req == 2'b01)      m_owner = 0;
        else if (req == 2'b10) m_owner = 1;
        else                   m_owner = (m_last == 1) ? 0 : 1;
        m_len  = (m_owner == 1) ? int'(len1) : int'(len0);
        m_el   = 0;
        m_busy = 1'b1;
      end
    end else if (m_el <= m_len) begin
      if (!pz) m_el++;
    end else begin
      m_busy = 1'b0;
      m_last = m_owner;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [1:0] rq, input logic [W-1:0] l0,
                               input logic [W-1:0] l1, input logic p);
    reset = r; req = rq; len0 = l0; len1 = l1; pause = p;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput({phase, "_grant"}, 32'(grant), 32'(expGrant()));
    checkOutput({phase, "_count"}, 32'(count), 32'(expCount()));
    checkOutput({phase, "_busy"},  32'(busy),  32'(m_busy));
    checkOutput({phase, "_done"},  32'(done),  32'(expDone()));
  endtask

  initial begin
    logic [1:0] prev_grant;
    logic [1:0] order_q[$];
    logic [1:0] rq;
    reset = 1'b1; req = 2'b00; len0 = '0; len1 = '0; pause = 1'b0;
    @(negedge clk);

    phase = "reset";
    applyStimulus(1'b1, 2'b00, 8'd0, 8'd0, 1'b0);
    applyStimulus(1'b1, 2'b11, 8'd7, 8'd7, 1'b0);

    // Single request of length 3; requester drops req once done is seen
    phase = "single";
    applyStimulus(1'b0, 2'b01, 8'd3, 8'd9, 1'b0);
    checkOutput("single_first_grant", 32'(grant), 32'd1);
    checkOutput("single_first_count", 32'(count), 32'd3);
    rq = 2'b01;
    for (int i = 0; i < 8; i++) begin
      if (expDone() != 2'b00) rq = 2'b00;
      applyStimulus(1'b0, rq, 8'd200, 8'd9, 1'b0);
    end

    // Both requests held: service must alternate starting with requester 0
    phase = "tie";
    applyStimulus(1'b1, 2'b00, 8'd0, 8'd0, 1'b0);
    prev_grant = 2'b00;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 2'b11, 8'd2, 8'd1, 1'b0);
      if (prev_grant == 2'b00 && grant != 2'b00) order_q.push_back(grant);
      prev_grant = grant;
    end
    if (order_q.size() < 3)
      checkOutput("tie_njobs", 32'(order_q.size()), 32'd3);
    else begin
      checkOutput("tie_order0", 32'(order_q[0]), 32'd1);
      checkOutput("tie_order1", 32'(order_q[1]), 32'd2);
      checkOutput("tie_order2", 32'(order_q[2]), 32'd1);
    end

    // Zero length: one RUN cycle at 0, then done
    phase = "len0";
    applyStimulus(1'b1, 2'b00, 8'd0, 8'd0, 1'b0);
    applyStimulus(1'b0, 2'b01, 8'd0, 8'd5, 1'b0);
    checkOutput("len0_run_count", 32'(count), 32'd0);
    applyStimulus(1'b0, 2'b01, 8'd0, 8'd5, 1'b0);
    checkOutput("len0_done", 32'(done), 32'd1);
    applyStimulus(1'b0, 2'b00, 8'd0, 8'd5, 1'b0);

    // Abort at count 5: pointer must return to favouring requester 0
    phase = "abort";
    applyStimulus(1'b0, 2'b01, 8'd9, 8'd3, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 2'b01, 8'd9, 8'd3, 1'b0);
    checkOutput("abort_count5", 32'(count), 32'd5);
    applyStimulus(1'b1, 2'b01, 8'd9, 8'd3, 1'b0);
    checkOutput("abort_count0", 32'(count), 32'd0);
    checkOutput("abort_grant0", 32'(grant), 32'd0);
    applyStimulus(1'b0, 2'b11, 8'd1, 8'd1, 1'b0);
    checkOutput("abort_tie_grant", 32'(grant), 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'b00, 8'd1, 8'd1, 1'b0);

    // Full-scale length on requester 1, request dropped right after grant
    phase = "maxlen";
    applyStimulus(1'b0, 2'b10, 8'd1, 8'd255, 1'b0);
    for (int i = 0; i < 258; i++) applyStimulus(1'b0, 2'b00, 8'd4, 8'd17, 1'b0);

`ifdef TIMER_SCHED_PAUSE_EN
    phase = "pause";
    applyStimulus(1'b1, 2'b00, 8'd0, 8'd0, 1'b0);
    applyStimulus(1'b0, 2'b01, 8'd4, 8'd0, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 2'b00, 8'd4, 8'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 2'b00, 8'd4, 8'd0, 1'b1);
      checkOutput("pause_hold", 32'(count), 32'd2);
    end
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 2'b00, 8'd4, 8'd0, 1'b0);
`endif

    // Random traffic, including mid-job length changes, pauses and resets
    phase = "random";
    for (int i = 0; i < 3000; i++)
      applyStimulus(($urandom_range(0, 80) == 0), 2'($urandom_range(0, 3)),
                    W'($urandom_range(0, 12)), W'($urandom_range(0, 12)),
                    ($urandom_range(0, 3) == 0));

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
